// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES round-constant generator.
//   ksize_e        - key-size encoding carried on the ksize port
//   rcon_state_e   - generator state (IDLE / RUN / DONE)
//   POLY_DEFAULT   - GF(2^8) reduction byte used by xtime
//   RCON_CNT_*     - number of round constants needed per key size
//   rcon_count()   - maps a key size to its constant count
package aes_pkg;

  typedef enum logic [1:0] {
    KS_128  = 2'd0,
    KS_192  = 2'd1,
    KS_256  = 2'd2,
    KS_RSVD = 2'd3
  } ksize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rcon_state_e;

  localparam logic [7:0] POLY_DEFAULT = 8'h1b;

  localparam logic [3:0] RCON_CNT_128 = 4'd10;
  localparam logic [3:0] RCON_CNT_192 = 4'd8;
  localparam logic [3:0] RCON_CNT_256 = 4'd7;

  // Highest index any key size can reach.
  localparam logic [3:0] RIDX_MAX = RCON_CNT_128 - 4'd1;

  // The reserved encoding falls back to the AES-128 schedule length.
  function automatic logic [3:0] rcon_count(input ksize_e ks);
    logic [3:0] cnt;
    case (ks)
      KS_128:  cnt = RCON_CNT_128;
      KS_192:  cnt = RCON_CNT_192;
      KS_256:  cnt = RCON_CNT_256;
      default: cnt = RCON_CNT_128;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/aes_xtime.sv
// aes_xtime: combinational GF(2^8) multiply-by-2.
//   din  [7:0] - operand byte
//   dout [7:0] - din * x, reduced with POLY when the top bit falls out
module aes_xtime #(
  parameter logic [7:0] POLY = 8'h1b
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Shift left; fold the carried-out bit back in with the reduction byte.
  always_comb begin
    dout = {din[6:0], 1'b0};
    if (din[7]) begin
      dout = dout ^ POLY;
    end else begin
      dout = dout;
    end
  end

endmodule

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: AES key-schedule round-constant generator.
// The constant is produced by repeated xtime from 8'h01 rather than from a
// table, so the sequence is 01,02,04,08,10,20,40,80,1b,36 for the default POLY.
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - asynchronous active-high reset
//   kld         - restart at the first constant and latch ksize (beats adv)
//   ksize [1:0] - key size: 0=128, 1=192, 2=256, 3=treated as 128
//   adv         - step to the next constant while running
//   out [OUT_W-1:0] - constant byte in the top 8 bits, zeros below
//   ridx  [3:0] - zero-based index of the current constant
//   last        - current constant is the final one for the latched size
//   busy        - high while the sequence is running
module aes_rcon_gen
  import aes_pkg::*;
#(
  parameter int         OUT_W = 32,
  parameter logic [7:0] POLY  = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kld,
  input  logic [1:0]       ksize,
  input  logic             adv,
  output logic [OUT_W-1:0] out,
  output logic [3:0]       ridx,
  output logic             last,
  output logic             busy
);

  rcon_state_e state_r, state_s;
  ksize_e      ksize_r, ksize_s;
  logic [7:0]  rcon_r,  rcon_s;
  logic [3:0]  ridx_r,  ridx_s;
  logic        last_r,  last_s;
  logic        busy_r,  busy_s;
  logic [7:0]  rcon_x2_s;

  aes_xtime #(
    .POLY (POLY)
  ) u_xtime (
    .din  (rcon_r),
    .dout (rcon_x2_s)
  );

  // Next-state, next-constant and registered-flag computation.
  always_comb begin
    state_s = state_r;
    ksize_s = ksize_r;
    rcon_s  = rcon_r;
    ridx_s  = ridx_r;

    if (kld) begin
      state_s = ST_RUN;
      ksize_s = ksize_e'(ksize);
      rcon_s  = 8'h01;
      ridx_s  = 4'd0;
    end else if (adv) begin
      case (state_r)
        ST_RUN: begin
          // The index bound is a backstop: last_r should always fire first.
          if (last_r || (ridx_r >= RIDX_MAX)) begin
            state_s = ST_DONE;
            rcon_s  = 8'h00;
            ridx_s  = 4'd0;
          end else begin
            rcon_s  = rcon_x2_s;
            ridx_s  = ridx_r + 4'd1;
          end
        end
        ST_IDLE: begin
          state_s = state_r;
        end
        ST_DONE: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
          rcon_s  = 8'h00;
          ridx_s  = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // Flags are derived from the next state so they can be registered.
    busy_s = (state_s == ST_RUN);
    if (state_s == ST_RUN) begin
      last_s = (ridx_s == (rcon_count(ksize_s) - 4'd1));
    end else begin
      last_s = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ksize_r <= KS_128;
      rcon_r  <= 8'h00;
      ridx_r  <= 4'd0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ksize_r <= ksize_s;
      rcon_r  <= rcon_s;
      ridx_r  <= ridx_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
    end
  end

  // Place the constant byte in the top of the output word.
  always_comb begin
    out = '0;
    out[OUT_W-1 -: 8] = rcon_r;
  end

  assign ridx = ridx_r;
  assign last = last_r;
  assign busy = busy_r;

endmodule
